// File: rtl/dpll_lock_ctrl.sv
// DPLL band-search and lock controller: settles each band, counts clk_fb edges over a window, locks or steps.
// Define DPLL_LOCK_CTRL_RELOCK_EN to keep measuring while LOCKED and restart the search after two misses.
module dpll_lock_ctrl #(
   parameter int WIN_CYC    = 1024,
   parameter int SETTLE_CYC = 256,
   parameter int TOL        = 2,
   parameter int CNT_W      = 12
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] target_cnt,
   input  logic             clk_fb,
   output logic [1:0]       freq_select,
   output logic             dpll_en,
   output logic             busy,
   output logic             locked,
   output logic             fail,
   output logic [CNT_W-1:0] meas_cnt
);

   localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_CHECK, S_LOCKED, S_FAIL} state_t;

   state_t             r_state;
   logic [1:0]         r_rst_sync;
   logic [1:0]         r_fb_sync;
   logic               r_fb_q;
   logic [TMR_W-1:0]   r_tmr;
   logic [CNT_W-1:0]   r_edge_cnt;
   logic               w_rst_n;
   logic               w_fb_rise;
   logic               w_settle_end;
   logic               w_win_end;
   logic [CNT_W-1:0]   w_edge_next;
   logic [CNT_W:0]     w_err_chk;

   function automatic logic [CNT_W:0] f_abs_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      logic [CNT_W:0] ea;
      logic [CNT_W:0] eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      return (ea >= eb) ? (ea - eb) : (eb - ea);
   endfunction

   // Reset asserts asynchronously but releases two clocks after wb_rst_ni rises.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) r_rst_sync <= 2'b00;
      else            r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_fb_sync <= 2'b00;
         r_fb_q    <= 1'b0;
      end else begin
         r_fb_sync <= {r_fb_sync[0], clk_fb};
         r_fb_q    <= r_fb_sync[1];
      end
   end

   assign w_fb_rise    = r_fb_sync[1] & ~r_fb_q;
   assign w_edge_next  = (w_fb_rise && !(&r_edge_cnt)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
   assign w_settle_end = (r_tmr == TMR_W'(SETTLE_CYC - 1));
   assign w_win_end    = (r_tmr == TMR_W'(WIN_CYC - 1));
   assign w_err_chk    = f_abs_diff(meas_cnt, target_cnt);

`ifdef DPLL_LOCK_CTRL_RELOCK_EN
   logic [CNT_W-1:0] r_tgt;
   logic             r_miss;
   logic [CNT_W:0]   w_err_mon;
   assign w_err_mon = f_abs_diff(w_edge_next, r_tgt);
`endif

   always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= S_IDLE;
         freq_select <= 2'd0;
         dpll_en     <= 1'b0;
         busy        <= 1'b0;
         locked      <= 1'b0;
         fail        <= 1'b0;
         meas_cnt    <= '0;
         r_tmr       <= '0;
         r_edge_cnt  <= '0;
`ifdef DPLL_LOCK_CTRL_RELOCK_EN
         r_tgt       <= '0;
         r_miss      <= 1'b0;
`endif
      end else if (abort) begin
         r_state     <= S_IDLE;
         freq_select <= 2'd0;
         dpll_en     <= 1'b0;
         busy        <= 1'b0;
         locked      <= 1'b0;
         fail        <= 1'b0;
         r_tmr       <= '0;
         r_edge_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_LOCKED, S_FAIL: begin
               if (start) begin
                  r_state     <= S_SETTLE;
                  freq_select <= 2'd0;
                  dpll_en     <= 1'b1;
                  busy        <= 1'b1;
                  locked      <= 1'b0;
                  fail        <= 1'b0;
                  r_tmr       <= '0;
               end
`ifdef DPLL_LOCK_CTRL_RELOCK_EN
               else if (r_state == S_LOCKED) begin
                  r_edge_cnt <= w_edge_next;
                  r_tmr      <= r_tmr + TMR_W'(1);
                  if (w_win_end) begin
                     r_tmr      <= '0;
                     r_edge_cnt <= '0;
                     meas_cnt   <= w_edge_next;
                     if (w_err_mon <= (CNT_W+1)'(TOL)) begin
                        r_miss <= 1'b0;
                     end else if (r_miss) begin
                        r_miss      <= 1'b0;
                        r_state     <= S_SETTLE;
                        freq_select <= 2'd0;
                        dpll_en     <= 1'b1;
                        busy        <= 1'b1;
                        locked      <= 1'b0;
                     end else begin
                        r_miss <= 1'b1;
                     end
                  end
               end
`endif
            end
            S_SETTLE: begin
               if (w_settle_end) begin
                  r_state    <= S_MEASURE;
                  r_tmr      <= '0;
                  r_edge_cnt <= '0;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            S_MEASURE: begin
               r_edge_cnt <= w_edge_next;
               if (w_win_end) begin
                  r_state  <= S_CHECK;
                  meas_cnt <= w_edge_next;
                  r_tmr    <= '0;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            S_CHECK: begin
               if (w_err_chk <= (CNT_W+1)'(TOL)) begin
                  r_state    <= S_LOCKED;
                  locked     <= 1'b1;
                  busy       <= 1'b0;
                  r_tmr      <= '0;
                  r_edge_cnt <= '0;
`ifdef DPLL_LOCK_CTRL_RELOCK_EN
                  r_tgt      <= target_cnt;
                  r_miss     <= 1'b0;
`endif
               end else if (freq_select != 2'd3) begin
                  r_state     <= S_SETTLE;
                  freq_select <= freq_select + 2'd1;
                  r_tmr       <= '0;
               end else begin
                  r_state <= S_FAIL;
                  fail    <= 1'b1;
                  dpll_en <= 1'b0;
                  busy    <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Directed bench for dpll_lock_ctrl: table of band-search outcomes plus abort, reset and relock sequences.
module tb_dpll_lock_ctrl;

   localparam int CNT_W = 12;
   localparam int BAND  = 81;

   logic             wb_clk_i = 1'b0;
   logic             wb_rst_ni;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] target_cnt;
   logic             clk_fb = 1'b0;
   logic [1:0]       freq_select;
   logic             dpll_en;
   logic             busy;
   logic             locked;
   logic             fail;
   logic [CNT_W-1:0] meas_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   dpll_lock_ctrl #(.WIN_CYC(64), .SETTLE_CYC(16), .TOL(2), .CNT_W(CNT_W)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .start(start), .abort(abort),
      .target_cnt(target_cnt), .clk_fb(clk_fb), .freq_select(freq_select),
      .dpll_en(dpll_en), .busy(busy), .locked(locked), .fail(fail), .meas_cnt(meas_cnt)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // DPLL model: period (16 >> band) clocks; force_en pins it to band 2 (period 4).
   logic [7:0] fb_ph = '0;
   logic       force_en = 1'b0;
   int         eff_fs;
   always @(negedge wb_clk_i) begin
      fb_ph  = fb_ph + 8'd1;
      eff_fs = force_en ? 2 : int'(freq_select);
      clk_fb = fb_ph[3 - eff_fs];
   end

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [CNT_W-1:0] tgt;
      int               nb;
      logic             e_lock;
      logic             e_fail;
      logic [1:0]       e_fs;
      logic [CNT_W-1:0] e_meas;
   } vec_t;

   vec_t vt[6];
   int   e;

   initial begin
      vt[0] = '{12'd4,   1, 1'b1, 1'b0, 2'd0, 12'd4};
      vt[1] = '{12'd16,  3, 1'b1, 1'b0, 2'd2, 12'd16};
      vt[2] = '{12'd100, 4, 1'b0, 1'b1, 2'd3, 12'd32};
      vt[3] = '{12'd6,   1, 1'b1, 1'b0, 2'd0, 12'd4};
      vt[4] = '{12'd7,   2, 1'b1, 1'b0, 2'd1, 12'd8};
      vt[5] = '{12'd34,  4, 1'b1, 1'b0, 2'd3, 12'd32};

      wb_rst_ni  = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      target_cnt = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_dpll_en", dpll_en, 0);
      chk("rst_locked", locked, 0);
      chk("rst_fail", fail, 0);
      chk("rst_fs", freq_select, 0);
      chk("rst_meas", meas_cnt, 0);
      wb_rst_ni = 1'b1;
      repeat (3) tick();

      for (int v = 0; v < 6; v++) begin
         target_cnt = vt[v].tgt;
         start = 1'b1;
         tick();
         start = 1'b0;
         e = 0;
         chk("start_busy", busy, 1);
         chk("start_dpll_en", dpll_en, 1);
         chk("start_fs", freq_select, 0);
         chk("start_locked", locked, 0);
         for (int b = 0; b < vt[v].nb; b++) begin
            while (e < BAND*b + 40) begin tick(); e++; end
            chk("band_fs", freq_select, b);
            chk("band_busy", busy, 1);
         end
         while (e < BAND*vt[v].nb - 1) begin tick(); e++; end
         chk("pre_dec_busy", busy, 1);
         tick(); tick();
         chk("end_busy", busy, 0);
         chk("end_locked", locked, vt[v].e_lock);
         chk("end_fail", fail, vt[v].e_fail);
         chk("end_dpll_en", dpll_en, !vt[v].e_fail);
         chk("end_fs", freq_select, vt[v].e_fs);
         chk("end_meas", meas_cnt, vt[v].e_meas);
      end

      // abort mid-MEASURE of band 1, with a simultaneous start
      target_cnt = 12'd16;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (119) tick();
      chk("ab_pre_fs", freq_select, 1);
      chk("ab_pre_busy", busy, 1);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_dpll_en", dpll_en, 0);
      chk("ab_fs", freq_select, 0);
      chk("ab_locked", locked, 0);
      chk("ab_meas_held", meas_cnt, 4);
      repeat (5) tick();
      chk("ab_stay_idle", busy, 0);

      // asynchronous reset mid-SETTLE, then start release timing
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("rs_pre_busy", busy, 1);
      #3;
      wb_rst_ni = 1'b0;
      #1;
      chk("rs_busy", busy, 0);
      chk("rs_dpll_en", dpll_en, 0);
      chk("rs_meas", meas_cnt, 0);
      chk("rs_locked", locked, 0);
      chk("rs_fail", fail, 0);
      chk("rs_fs", freq_select, 0);
      repeat (2) tick();
      wb_rst_ni = 1'b1;
      tick();
      start = 1'b1;
      tick();
      chk("rs_start_early", busy, 0);
      tick();
      start = 1'b0;
      chk("rs_start_ok", busy, 1);

`ifdef DPLL_LOCK_CTRL_RELOCK_EN
      abort = 1'b1;
      tick();
      abort = 1'b0;
      target_cnt = 12'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (163) tick();
      chk("rl_locked", locked, 1);
      chk("rl_fs", freq_select, 1);
      chk("rl_meas", meas_cnt, 8);
      force_en = 1'b1;
      repeat (126) tick();
      chk("rl_one_miss", locked, 1);
      tick();
      chk("rl_lost", locked, 0);
      chk("rl_busy", busy, 1);
      chk("rl_fs0", freq_select, 0);
      chk("rl_dpll_en", dpll_en, 1);
      chk("rl_meas_win", meas_cnt, 16);
      force_en = 1'b0;
      repeat (163) tick();
      chk("rl_relocked", locked, 1);
      chk("rl_relock_fs", freq_select, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dpll_lock_ctrl.md
DPLL_LOCK_CTRL -- requirements
Module: dpll_lock_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_CYC, default 1024: measurement window length in wb_clk_i cycles.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 256: settle time in wb_clk_i cycles after each band change.
REQ-003 The block SHALL have parameter TOL, default 2: allowed absolute error in edge count.
REQ-004 The block SHALL have parameter CNT_W, default 12: width of the edge counter and target.
REQ-005 The block SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins band search.
REQ-008 The block SHALL have port abort, input, 1 bit: one-cycle pulse that returns the block to idle.
REQ-009 The block SHALL have port target_cnt, input, CNT_W bits: expected clk_fb rising edges per window.
REQ-010 The block SHALL have port clk_fb, input, 1 bit: DPLL feedback output, asynchronous to wb_clk_i.
REQ-011 The block SHALL have port freq_select, output, 2 bits: DPLL band select.
REQ-012 The block SHALL have port dpll_en, output, 1 bit: DPLL enable.
REQ-013 The block SHALL have port busy, output, 1 bit: high while searching.
REQ-014 The block SHALL have port locked, output, 1 bit: high while in lock.
REQ-015 The block SHALL have port fail, output, 1 bit: high when no band locked.
REQ-016 The block SHALL have port meas_cnt, output, CNT_W bits: edge count from the last completed window.

Function
REQ-017 The block SHALL pass clk_fb through a 2-FF synchronizer; a rising edge is a synchronized 0->1 transition.
REQ-018 The edge counter SHALL count only in MEASURE, clear on MEASURE entry, and saturate at all-ones.
REQ-019 The FSM states SHALL be IDLE, SETTLE, MEASURE, CHECK, LOCKED and FAIL.
REQ-020 On start in IDLE, LOCKED or FAIL, the next cycle SHALL have freq_select=0, dpll_en=1, busy=1, locked=0, fail=0 and state SETTLE.
REQ-021 In SETTLE the block SHALL wait exactly SETTLE_CYC cycles, then enter MEASURE.
REQ-022 In MEASURE the block SHALL count for exactly WIN_CYC cycles, then enter CHECK and latch the count into meas_cnt.
REQ-023 CHECK SHALL last one cycle and compute |meas_cnt - target_cnt| in CNT_W+1 bits, unsigned.
REQ-024 In CHECK, if the error is <= TOL, the next state SHALL be LOCKED with locked=1 and busy=0.
REQ-025 In CHECK, if the error is > TOL and freq_select<3, freq_select SHALL increment and the next state SHALL be SETTLE.
REQ-026 In CHECK, if the error is > TOL and freq_select=3, the next state SHALL be FAIL with fail=1, dpll_en=0 and busy=0.
REQ-027 Per-band latency from SETTLE entry to the CHECK decision SHALL be SETTLE_CYC+WIN_CYC+1 cycles.
REQ-028 start in SETTLE, MEASURE or CHECK SHALL be ignored.
REQ-029 abort in any state SHALL give, next cycle: IDLE, dpll_en=0, freq_select=0, busy=0, locked=0, fail=0; meas_cnt is held.
REQ-030 When abort and start are asserted together, abort SHALL win.
REQ-031 target_cnt SHALL be sampled only in CHECK.

Reset
REQ-032 With wb_rst_ni=0, the block SHALL immediately force IDLE with freq_select=0, dpll_en=0, busy=0, locked=0, fail=0, meas_cnt=0, all counters 0 and synchronizer flops 0.
REQ-033 Reset deassertion SHALL be synchronized, and the first start SHALL be honoured no earlier than 2 cycles after deassertion.

Configuration
REQ-034 The relock monitor SHALL be compiled in when DPLL_LOCK_CTRL_RELOCK_EN is defined.
REQ-035 Without DPLL_LOCK_CTRL_RELOCK_EN, LOCKED SHALL be static until start or abort.
REQ-036 With DPLL_LOCK_CTRL_RELOCK_EN, LOCKED SHALL run back-to-back WIN_CYC windows and update meas_cnt after each window.
REQ-037 With DPLL_LOCK_CTRL_RELOCK_EN, two consecutive out-of-tolerance windows SHALL clear locked and restart the search as in REQ-020.
REQ-038 With DPLL_LOCK_CTRL_RELOCK_EN, one in-tolerance window SHALL clear the miss count.

Verification
Bench setup: WIN_CYC=64, SETTLE_CYC=16, TOL=2; the clk_fb model period is (16>>freq_select) wb_clk_i cycles, giving counts 4/8/16/32.
REQ-039 Bench SHALL cover: target_cnt=4, start -> locked=1, freq_select=0, meas_cnt=4, 82 cycles after start.
REQ-040 Bench SHALL cover: target_cnt=16 -> freq_select steps 0,1,2, then locked=1, meas_cnt=16, busy low after 3x81 cycles.
REQ-041 Bench SHALL cover: target_cnt=100 -> after four bands, fail=1, dpll_en=0, freq_select=3, meas_cnt=32.
REQ-042 Bench SHALL cover: abort mid-MEASURE at band 1 -> next cycle IDLE, dpll_en=0, freq_select=0; a start in the same cycle is ignored.
REQ-043 Bench SHALL cover: wb_rst_ni low mid-SETTLE -> all outputs 0 without a clock edge.
REQ-044 Bench SHALL cover: with RELOCK_EN, locked at target 8, then the model is forced to period 4 for two windows -> locked=0, search restarts at freq_select=0.
